// File: rtl/map_lookup_arb.sv
// ----------------------------------------------------------------------------
// map_lookup_arb : register key/data table, two-requester round-robin lookup
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module map_lookup_arb #(
   parameter int NR_KEY   = 4,
   parameter int KEY_LEN  = 7,
   parameter int DATA_LEN = 8,
   localparam int IDX_W   = $clog2(NR_KEY)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [IDX_W-1:0]    cfg_idx,
   input  logic [KEY_LEN-1:0]  cfg_key,
   input  logic [DATA_LEN-1:0] cfg_data,
   input  logic                cfg_clear,
   input  logic                req0_valid,
   input  logic [KEY_LEN-1:0]  req0_key,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [KEY_LEN-1:0]  req1_key,
   output logic                req1_ready,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_LEN-1:0] rsp_data,
   output logic                rsp_hit,
   output logic                rsp_id
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic [NR_KEY-1:0]   valid_q, valid_d;
   logic [KEY_LEN-1:0]  key_q  [NR_KEY];
   logic [KEY_LEN-1:0]  key_d  [NR_KEY];
   logic [DATA_LEN-1:0] data_q [NR_KEY];
   logic [DATA_LEN-1:0] data_d [NR_KEY];
   logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
   logic                rsp_hit_q, rsp_hit_d;
   logic                rsp_id_q, rsp_id_d;

   logic                slot_free;
   logic                gnt0, gnt1;
   logic [KEY_LEN-1:0]  lk_key;
   logic                lk_hit;
   logic [DATA_LEN-1:0] lk_data;

   // last_q=1 means requester 1 was granted last, so requester 0 wins a tie.
   always_comb begin
      slot_free = (state_q == ST_EMPTY) || rsp_ready;
      gnt0      = slot_free && req0_valid && (!req1_valid || last_q);
      gnt1      = slot_free && req1_valid && (!req0_valid || !last_q);
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // Lookup reads the current (pre-write) table contents.
   always_comb begin
      lk_key  = gnt1 ? req1_key : req0_key;
      lk_hit  = 1'b0;
      lk_data = '0;
      for (int i = 0; i < NR_KEY; i++) begin
         if (valid_q[i] && (key_q[i] == lk_key)) begin
            lk_hit  = 1'b1;
            lk_data = lk_data | data_q[i];
         end
      end
   end

   always_comb begin
      valid_d = cfg_clear ? '0 : valid_q;
      key_d   = key_q;
      data_d  = data_q;
      if (cfg_we) begin
         valid_d[cfg_idx] = 1'b1;
         key_d[cfg_idx]   = cfg_key;
         data_d[cfg_idx]  = cfg_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      rsp_data_d = rsp_data_q;
      rsp_hit_d  = rsp_hit_q;
      rsp_id_d   = rsp_id_q;
      if (gnt0 || gnt1) begin
         state_d    = ST_FULL;
         last_d     = gnt1;
         rsp_data_d = lk_data;
         rsp_hit_d  = lk_hit;
         rsp_id_d   = gnt1;
      end else if (rsp_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         last_q     <= 1'b1;
         valid_q    <= '0;
         rsp_data_q <= '0;
         rsp_hit_q  <= 1'b0;
         rsp_id_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         valid_q    <= valid_d;
         rsp_data_q <= rsp_data_d;
         rsp_hit_q  <= rsp_hit_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   // Key/data storage is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_q  <= key_d;
         data_q <= data_d;
      end
   end

   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_data  = rsp_data_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_id    = rsp_id_q;

endmodule

`default_nettype wire

// File: tb/tb_map_lookup_arb.sv
// ----------------------------------------------------------------------------
// tb_map_lookup_arb : directed self-checking bench for map_lookup_arb
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_map_lookup_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [1:0] cfg_idx;
   logic [6:0] cfg_key;
   logic [7:0] cfg_data;
   logic       cfg_clear;
   logic       req0_valid, req1_valid;
   logic [6:0] req0_key, req1_key;
   logic       req0_ready, req1_ready;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_hit, rsp_id;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   map_lookup_arb #(.NR_KEY(4), .KEY_LEN(7), .DATA_LEN(8)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
      .cfg_data(cfg_data), .cfg_clear(cfg_clear),
      .req0_valid(req0_valid), .req0_key(req0_key), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_key(req1_key), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_hit(rsp_hit), .rsp_id(rsp_id)
   );

   // Inputs change 1ns after the rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cfg_we = 0; cfg_idx = 0; cfg_key = 0; cfg_data = 0; cfg_clear = 0;
      req0_valid = 0; req0_key = 0; req1_valid = 0; req1_key = 0;
      rsp_ready = 1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic write_entry(input logic [1:0] idx, input logic [6:0] k,
                              input logic [7:0] d);
      cfg_we = 1; cfg_idx = idx; cfg_key = k; cfg_data = d;
      step();
      cfg_we = 0;
   endtask

   // Checks the held response against {valid, data, hit, id}.
   task automatic test_reset();
      do_reset();
      #1;
      n_vec++;
      if ({rsp_valid, rsp_data, rsp_hit, rsp_id} !== 11'h000) begin
         $display("FAIL reset_outputs: got v=%b d=%h h=%b id=%b expected all 0",
                  rsp_valid, rsp_data, rsp_hit, rsp_id);
         n_err++;
      end
      n_vec++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         $display("FAIL reset_ready_idle: got %b expected 00", {req0_ready, req1_ready});
         n_err++;
      end
   endtask

   task automatic test_hit();
      do_reset();
      write_entry(2'd0, 7'h05, 8'hA5);
      req0_valid = 1; req0_key = 7'h05;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         $display("FAIL hit_ready: got %b expected 10", {req0_ready, req1_ready});
         n_err++;
      end
      step();
      req0_valid = 0;
      n_vec++;
      if ({rsp_valid, rsp_data, rsp_hit, rsp_id} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin
         $display("FAIL hit_rsp: got v=%b d=%h h=%b id=%b expected v=1 d=a5 h=1 id=0",
                  rsp_valid, rsp_data, rsp_hit, rsp_id);
         n_err++;
      end
      step();
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         $display("FAIL hit_drain: got rsp_valid=%b expected 0", rsp_valid);
         n_err++;
      end
   endtask

   task automatic test_miss();
      do_reset();
      req1_valid = 1; req1_key = 7'h05;
      step();
      req1_valid = 0;
      n_vec++;
      if ({rsp_valid, rsp_data, rsp_hit, rsp_id} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
         $display("FAIL miss_rsp: got v=%b d=%h h=%b id=%b expected v=1 d=00 h=0 id=1",
                  rsp_valid, rsp_data, rsp_hit, rsp_id);
         n_err++;
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_rdy;
      do_reset();
      write_entry(2'd3, 7'h22, 8'h5C);
      req0_valid = 1; req0_key = 7'h22;
      req1_valid = 1; req1_key = 7'h22;
      for (int k = 0; k < 4; k++) begin
         #1;
         exp_rdy = (k % 2 == 0) ? 2'b10 : 2'b01;
         n_vec++;
         if ({req0_ready, req1_ready} !== exp_rdy) begin
            $display("FAIL rr_ready[%0d]: got %b expected %b", k,
                     {req0_ready, req1_ready}, exp_rdy);
            n_err++;
         end
         step();
         n_vec++;
         if ({rsp_valid, rsp_data, rsp_hit, rsp_id} !==
             {1'b1, 8'h5C, 1'b1, (k % 2 == 1)}) begin
            $display("FAIL rr_rsp[%0d]: got v=%b d=%h h=%b id=%b expected v=1 d=5c h=1 id=%0d",
                     k, rsp_valid, rsp_data, rsp_hit, rsp_id, k % 2);
            n_err++;
         end
      end
      req0_valid = 0; req1_valid = 0;
      step();
   endtask

   task automatic test_stall();
      do_reset();
      write_entry(2'd0, 7'h05, 8'hA5);
      req0_valid = 1; req0_key = 7'h05;
      step();
      req0_valid = 0;
      rsp_ready = 0;
      req1_valid = 1; req1_key = 7'h05;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_vec++;
         if ({req0_ready, req1_ready} !== 2'b00) begin
            $display("FAIL stall_ready[%0d]: got %b expected 00", k, {req0_ready, req1_ready});
            n_err++;
         end
         n_vec++;
         if ({rsp_valid, rsp_data, rsp_hit, rsp_id} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin
            $display("FAIL stall_hold[%0d]: got v=%b d=%h h=%b id=%b expected v=1 d=a5 h=1 id=0",
                     k, rsp_valid, rsp_data, rsp_hit, rsp_id);
            n_err++;
         end
         step();
      end
      rsp_ready = 1;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         $display("FAIL stall_release_ready: got %b expected 01", {req0_ready, req1_ready});
         n_err++;
      end
      step();
      req1_valid = 0;
      n_vec++;
      if ({rsp_valid, rsp_data, rsp_hit, rsp_id} !== {1'b1, 8'hA5, 1'b1, 1'b1}) begin
         $display("FAIL stall_release_rsp: got v=%b d=%h h=%b id=%b expected v=1 d=a5 h=1 id=1",
                  rsp_valid, rsp_data, rsp_hit, rsp_id);
         n_err++;
      end
   endtask

   task automatic test_multi_match_clear();
      do_reset();
      write_entry(2'd0, 7'h05, 8'hA5);
      write_entry(2'd1, 7'h05, 8'h0F);
      req0_valid = 1; req0_key = 7'h05;
      step();
      req0_valid = 0;
      n_vec++;
      if ({rsp_data, rsp_hit} !== {8'hAF, 1'b1}) begin
         $display("FAIL multi_or: got d=%h h=%b expected d=af h=1", rsp_data, rsp_hit);
         n_err++;
      end
      cfg_clear = 1;
      step();
      cfg_clear = 0;
      req0_valid = 1;
      step();
      req0_valid = 0;
      n_vec++;
      if ({rsp_valid, rsp_data, rsp_hit} !== {1'b1, 8'h00, 1'b0}) begin
         $display("FAIL after_clear: got v=%b d=%h h=%b expected v=1 d=00 h=0",
                  rsp_valid, rsp_data, rsp_hit);
         n_err++;
      end
      // Clear together with a write: only the written entry survives.
      write_entry(2'd0, 7'h05, 8'hA5);
      cfg_clear = 1;
      write_entry(2'd1, 7'h06, 8'h66);
      cfg_clear = 0;
      req0_valid = 1; req0_key = 7'h05;
      step();
      n_vec++;
      if ({rsp_data, rsp_hit} !== {8'h00, 1'b0}) begin
         $display("FAIL clear_we_other: got d=%h h=%b expected d=00 h=0", rsp_data, rsp_hit);
         n_err++;
      end
      req0_key = 7'h06;
      step();
      req0_valid = 0;
      n_vec++;
      if ({rsp_data, rsp_hit} !== {8'h66, 1'b1}) begin
         $display("FAIL clear_we_kept: got d=%h h=%b expected d=66 h=1", rsp_data, rsp_hit);
         n_err++;
      end
   endtask

   task automatic test_same_cycle_write();
      do_reset();
      cfg_we = 1; cfg_idx = 2'd2; cfg_key = 7'h10; cfg_data = 8'h33;
      req0_valid = 1; req0_key = 7'h10;
      step();
      cfg_we = 0;
      n_vec++;
      if ({rsp_valid, rsp_data, rsp_hit} !== {1'b1, 8'h00, 1'b0}) begin
         $display("FAIL same_cycle_pre: got v=%b d=%h h=%b expected v=1 d=00 h=0",
                  rsp_valid, rsp_data, rsp_hit);
         n_err++;
      end
      step();
      req0_valid = 0;
      n_vec++;
      if ({rsp_valid, rsp_data, rsp_hit} !== {1'b1, 8'h33, 1'b1}) begin
         $display("FAIL same_cycle_post: got v=%b d=%h h=%b expected v=1 d=33 h=1",
                  rsp_valid, rsp_data, rsp_hit);
         n_err++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      write_entry(2'd0, 7'h05, 8'hA5);
      req0_valid = 1; req0_key = 7'h05;
      rsp_ready = 0;
      step();
      rst = 1;
      cfg_we = 1; cfg_idx = 2'd1; cfg_key = 7'h07; cfg_data = 8'h77;
      step();
      rst = 0; cfg_we = 0; req0_valid = 0; rsp_ready = 1;
      n_vec++;
      if ({rsp_valid, rsp_data, rsp_hit, rsp_id} !== 11'h000) begin
         $display("FAIL reset_mid_rsp: got v=%b d=%h h=%b id=%b expected all 0",
                  rsp_valid, rsp_data, rsp_hit, rsp_id);
         n_err++;
      end
      req1_valid = 1; req1_key = 7'h07;
      step();
      req1_valid = 0;
      n_vec++;
      if ({rsp_valid, rsp_data, rsp_hit, rsp_id} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
         $display("FAIL reset_mid_cfg_ignored: got v=%b d=%h h=%b id=%b expected v=1 d=00 h=0 id=1",
                  rsp_valid, rsp_data, rsp_hit, rsp_id);
         n_err++;
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      #1;
      test_reset();
      test_hit();
      test_miss();
      test_round_robin();
      test_stall();
      test_multi_match_clear();
      test_same_cycle_write();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/map_lookup_arb.md
MAP_LOOKUP_ARB -- requirements
Module: map_lookup_arb

Interface
REQ-001 SHALL have parameter NR_KEY, default 4, number of table entries (power of two, >=2).
REQ-002 SHALL have parameter KEY_LEN, default 7, key width in bits.
REQ-003 SHALL have parameter DATA_LEN, default 8, data width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_we  input  1  table entry write strobe.
REQ-007 SHALL have port cfg_idx  input  log2(NR_KEY)  entry index to write.
REQ-008 SHALL have port cfg_key  input  KEY_LEN  key to store.
REQ-009 SHALL have port cfg_data  input  DATA_LEN  data to store.
REQ-010 SHALL have port cfg_clear  input  1  invalidate all entries.
REQ-011 SHALL have ports req0_valid / req1_valid  input  1  lookup request from requester 0 / 1.
REQ-012 SHALL have ports req0_key / req1_key  input  KEY_LEN  lookup key.
REQ-013 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-014 SHALL have port rsp_valid  output  1  response held in output register.
REQ-015 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-016 SHALL have port rsp_data  output  DATA_LEN  lookup result.
REQ-017 SHALL have port rsp_hit  output  1  at least one valid entry matched.
REQ-018 SHALL have port rsp_id  output  1  requester that issued the request.

Function
REQ-019 SHALL hold NR_KEY entries, each {valid, key, data}, in registers.
REQ-020 SHALL, on cfg_we, write cfg_key/cfg_data to entry cfg_idx and set its valid bit.
REQ-021 SHALL, on cfg_clear, clear every valid bit; with cfg_we in the same cycle, the written entry ends valid and all others invalid.
REQ-022 SHALL make table writes visible to lookups accepted from the next cycle on; a lookup accepted in the same cycle as a write uses the pre-write table.
REQ-023 SHALL compute hit as the OR over entries of (valid AND key match), and data as the OR of the data of all valid matching entries; a miss gives data 0, hit 0.
REQ-024 SHALL keep a one-entry output register with two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-025 SHALL treat the slot as free when the state is EMPTY, or when FULL with rsp_ready=1 in the same cycle.
REQ-026 SHALL, when the slot is free, grant at most one requester and drive ready high only for the granted one.
REQ-027 SHALL drive both readies low when the slot is not free.
REQ-028 SHALL arbitrate round-robin via a last-grant pointer: with both requesting, grant the one not granted last.
REQ-029 SHALL grant a sole requester regardless of the pointer, and update the pointer only on a grant.
REQ-030 SHALL load the result, hit and id into the output register on a grant, giving response latency of exactly 1 cycle after acceptance.
REQ-031 SHALL support back-to-back throughput of one response per cycle while rsp_ready=1.
REQ-032 SHALL hold rsp_data/rsp_hit/rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-033 SHALL go FULL->EMPTY on rsp_ready=1 with no grant, and stay FULL on rsp_ready=1 with a grant (new response).
REQ-034 SHALL make readies a combinational function of state, rsp_ready and the req valids; the ready outputs SHALL not depend on the keys.

Reset
REQ-035 SHALL, on rst=1, clear all entry valid bits, set the state to EMPTY, drive rsp_valid=0, rsp_data=0, rsp_hit=0 and rsp_id=0, and set the pointer so requester 0 wins the first tie.
REQ-036 SHALL, on rst asserted mid-transaction, discard any held response and ignore cfg and req inputs in that cycle.

Verification
REQ-037 SHALL pass this case: write idx0 key=0x05 data=0xA5, then req0 key=0x05 next cycle -> rsp_valid next cycle, rsp_data=0xA5, rsp_hit=1, rsp_id=0.
REQ-038 SHALL pass this case: after reset, req1 key=0x05 -> rsp_hit=0, rsp_data=0x00, rsp_id=1.
REQ-039 SHALL pass this case: both requesters valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1, starting with 0, one response per cycle.
REQ-040 SHALL pass this case: rsp_ready=0 for 3 cycles while FULL -> both readies 0 and response unchanged; rsp_ready=1 -> pending requester granted the same cycle.
REQ-041 SHALL pass this case: idx1 key=0x05 data=0x0F plus idx0 as in REQ-037 -> lookup 0x05 returns 0xAF, hit=1; cfg_clear then lookup -> hit=0, data=0.
REQ-042 SHALL pass this case: cfg_we idx2 key=0x10 data=0x33 in the same cycle as a req0 key=0x10 grant -> miss; same lookup next cycle -> 0x33.
